game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per game step (legal range 2..255).
REQ-002 Parameter LIVES, default 3, lives loaded at reset/restart (legal range 1..3).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 resetFSM  input  1  synchronous, active-high reset.
REQ-005 btnStart  input  1  start/resume button level, already synchronous to clk.
REQ-006 btnPause  input  1  pause button level.
REQ-007 btnReset  input  1  game-reset button level.
REQ-008 collision  input  1  collision level from game logic.
REQ-009 stateGame  input  3  current game FSM state: 000 START, 001 PLAYING, 010 PAUSE, 011 RESET, 100 GAMEOVER.
REQ-010 startGame  output  1  one-cycle start/resume command to game FSM.
REQ-011 pauseGame  output  1  one-cycle pause command.
REQ-012 reset  output  1  one-cycle game-reset command.
REQ-013 dead  output  1  one-cycle last-life-lost indication.
REQ-014 stepTick  output  1  one-cycle game-step strobe.
REQ-015 lives  output  2  remaining lives.

Function
REQ-016 Each button and collision SHALL be edge-detected against a registered previous sample; an edge is sample 1 with previous sample 0.
REQ-017 A command pulse SHALL be registered: an edge sampled at clock edge k drives the output high for exactly the cycle following edge k.
REQ-018 Edges in the same cycle SHALL be prioritised reset > pause > start; at most one of startGame/pauseGame/reset is high per cycle; losing edges are dropped, not queued.
REQ-019 Start edge SHALL be accepted only when stateGame is 000 or 010; otherwise dropped.
REQ-020 Pause edge SHALL be accepted only when stateGame is 001; otherwise dropped.
REQ-021 Reset edge SHALL be accepted in every state except 011; otherwise dropped.
REQ-022 A rejected higher-priority edge SHALL NOT block an accepted lower-priority edge in the same cycle.
REQ-023 Step counter (8 bits) SHALL increment each cycle stateGame is 001; stepTick high for the cycle after the counter reaches TICK_DIV-1, counter wraps to 0.
REQ-024 Step counter SHALL hold its value while stateGame is 010 and clear to 0 in 000, 011, 100, and undefined states.
REQ-025 lives SHALL reload to LIVES in any cycle stateGame is 011.
REQ-026 A collision edge while stateGame is 001 and lives > 0 SHALL decrement lives by 1, visible the next cycle.
REQ-027 When that decrement takes lives from 1 to 0, dead SHALL be high in the same cycle lives first reads 0, for one cycle only.
REQ-028 lives SHALL saturate at 0; collision edges outside state 001 or at lives = 0 SHALL be ignored.
REQ-029 Collision processing, step ticking and command pulses SHALL be independent; any combination may occur in the same cycle.
REQ-030 Undefined stateGame values (101..111) SHALL accept no commands and no collisions.

Reset
REQ-031 While resetFSM is high: startGame, pauseGame, reset, dead, stepTick = 0; lives = LIVES; step counter = 0.
REQ-032 During resetFSM all previous-sample registers SHALL load 1, so a button or collision held through reset generates no edge until released and reasserted.
REQ-033 resetFSM asserted mid-operation SHALL override all function in that cycle; a pulse pending from the prior cycle is cancelled.

Verification
REQ-034 stateGame=000, btnStart 0->1 held 5 cycles -> startGame high exactly 1 cycle, one cycle after the sampling edge; no repeat while held.
REQ-035 stateGame=001, TICK_DIV=4, 12 cycles -> stepTick high on cycles 4, 8, 12; switch to 010 for 3 cycles then back to 001 -> next tick after the remaining count, not a full 4.
REQ-036 stateGame=001, btnPause and btnReset rise same cycle -> only reset pulses; stateGame=011 with btnReset and btnStart rising -> neither pulses; stateGame=010 with btnPause and btnStart rising -> only startGame pulses.
REQ-037 LIVES=3, stateGame=001, three collision pulses -> lives 2, 1, 0; dead high once with lives=0; fourth collision -> no change, no dead.
REQ-038 Hold btnStart high across resetFSM, release, press again at stateGame=000 -> no pulse after reset, one pulse after the re-press.
REQ-039 resetFSM asserted the cycle after a collision edge at lives=1 -> dead stays 0, lives = 3.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Bundle of button/collision/state inputs and command/status outputs
// exchanged between the game sequencer and its surroundings.
interface game_sequencer_if;
    logic       btnStart;
    logic       btnPause;
    logic       btnReset;
    logic       collision;
    logic [2:0] stateGame;
    logic       startGame;
    logic       pauseGame;
    logic       reset;
    logic       dead;
    logic       stepTick;
    logic [1:0] lives;

    // Environment side: drives the buttons and game state, observes commands.
    modport master (
        output btnStart, btnPause, btnReset, collision, stateGame,
        input  startGame, pauseGame, reset, dead, stepTick, lives
    );

    // Sequencer side: observes the buttons and game state, issues commands.
    modport slave (
        input  btnStart, btnPause, btnReset, collision, stateGame,
        output startGame, pauseGame, reset, dead, stepTick, lives
    );
endinterface

// File: rtl/game_sequencer.sv
// Game sequencer: turns button/collision edges into one-cycle commands,
// generates the game-step strobe and tracks remaining lives.
module game_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int LIVES    = 3
) (
    input  logic             clk,
    input  logic             resetFSM,
    game_sequencer_if.slave  bus
);
    localparam logic [2:0] ST_START    = 3'b000;
    localparam logic [2:0] ST_PLAYING  = 3'b001;
    localparam logic [2:0] ST_PAUSE    = 3'b010;
    localparam logic [2:0] ST_RESET    = 3'b011;
    localparam logic [2:0] ST_GAMEOVER = 3'b100;

    localparam logic [7:0] STEP_LAST  = 8'(TICK_DIV - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    // Previous samples load 1 in reset so a level held through reset is not an edge.
    logic       r_prev_start;
    logic       r_prev_pause;
    logic       r_prev_reset;
    logic       r_prev_coll;

    logic       r_start;
    logic       r_pause;
    logic       r_reset;
    logic       r_dead;
    logic       r_tick;
    logic [1:0] r_lives;
    logic [7:0] r_step_cnt;

    logic       w_start_edge;
    logic       w_pause_edge;
    logic       w_reset_edge;
    logic       w_coll_edge;
    logic       w_cmd_start;
    logic       w_cmd_pause;
    logic       w_cmd_reset;
    logic [7:0] w_step_next;
    logic       w_tick_next;
    logic [1:0] w_lives_next;
    logic       w_dead_next;

    assign w_start_edge = bus.btnStart  & ~r_prev_start;
    assign w_pause_edge = bus.btnPause  & ~r_prev_pause;
    assign w_reset_edge = bus.btnReset  & ~r_prev_reset;
    assign w_coll_edge  = bus.collision & ~r_prev_coll;

    // Command arbitration: only edges legal in the current state compete, reset > pause > start.
    always_comb begin
        w_cmd_start = 1'b0;
        w_cmd_pause = 1'b0;
        w_cmd_reset = 1'b0;
        if (w_reset_edge && (bus.stateGame == ST_START || bus.stateGame == ST_PLAYING ||
                             bus.stateGame == ST_PAUSE || bus.stateGame == ST_GAMEOVER)) begin
            w_cmd_reset = 1'b1;
        end else if (w_pause_edge && bus.stateGame == ST_PLAYING) begin
            w_cmd_pause = 1'b1;
        end else if (w_start_edge && (bus.stateGame == ST_START || bus.stateGame == ST_PAUSE)) begin
            w_cmd_start = 1'b1;
        end else begin
            w_cmd_start = 1'b0;
        end
    end

    // Step divider: count while playing, freeze while paused, clear otherwise.
    always_comb begin
        w_step_next = 8'd0;
        w_tick_next = 1'b0;
        case (bus.stateGame)
            ST_PLAYING: begin
                if (r_step_cnt == STEP_LAST) begin
                    w_step_next = 8'd0;
                    w_tick_next = 1'b1;
                end else begin
                    w_step_next = r_step_cnt + 8'd1;
                end
            end
            ST_PAUSE: w_step_next = r_step_cnt;
            default:  w_step_next = 8'd0;
        endcase
    end

    // Lives bookkeeping: reload in the reset state, lose one per collision while playing.
    always_comb begin
        w_lives_next = r_lives;
        w_dead_next  = 1'b0;
        case (bus.stateGame)
            ST_RESET: w_lives_next = LIVES_INIT;
            ST_PLAYING: begin
                if (w_coll_edge && r_lives != 2'd0) begin
                    w_lives_next = r_lives - 2'd1;
                    w_dead_next  = (r_lives == 2'd1);
                end else begin
                    w_lives_next = r_lives;
                end
            end
            default: w_lives_next = r_lives;
        endcase
    end

    // State and output registers; reset overrides everything, including pulses due next cycle.
    always_ff @(posedge clk) begin
        if (resetFSM) begin
            r_prev_start <= 1'b1;
            r_prev_pause <= 1'b1;
            r_prev_reset <= 1'b1;
            r_prev_coll  <= 1'b1;
            r_start      <= 1'b0;
            r_pause      <= 1'b0;
            r_reset      <= 1'b0;
            r_dead       <= 1'b0;
            r_tick       <= 1'b0;
            r_lives      <= LIVES_INIT;
            r_step_cnt   <= 8'd0;
        end else begin
            r_prev_start <= bus.btnStart;
            r_prev_pause <= bus.btnPause;
            r_prev_reset <= bus.btnReset;
            r_prev_coll  <= bus.collision;
            r_start      <= w_cmd_start;
            r_pause      <= w_cmd_pause;
            r_reset      <= w_cmd_reset;
            r_dead       <= w_dead_next;
            r_tick       <= w_tick_next;
            r_lives      <= w_lives_next;
            r_step_cnt   <= w_step_next;
        end
    end

    assign bus.startGame = r_start;
    assign bus.pauseGame = r_pause;
    assign bus.reset     = r_reset;
    assign bus.dead      = r_dead;
    assign bus.stepTick  = r_tick;
    assign bus.lives     = r_lives;
endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus a
// randomized run compared against a behavioural model of the game rules.
module tb_game_sequencer;
    localparam int TICK_DIV = 4;
    localparam int LIVES    = 3;

    logic clk;
    logic resetFSM;
    int   checks;
    int   errors;

    game_sequencer_if bus ();

    game_sequencer #(.TICK_DIV(TICK_DIV), .LIVES(LIVES)) dut (
        .clk      (clk),
        .resetFSM (resetFSM),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    bit m_prev_s, m_prev_p, m_prev_r, m_prev_c;
    int m_cnt;
    int m_lives;
    bit e_start, e_pause, e_reset, e_dead, e_tick;

    // Apply the game rules to the inputs seen at this clock edge.
    task automatic model_step();
        bit se, pe, re, ce;
        int st;
        if (resetFSM) begin
            e_start = 0; e_pause = 0; e_reset = 0; e_dead = 0; e_tick = 0;
            m_lives = LIVES; m_cnt = 0;
            m_prev_s = 1; m_prev_p = 1; m_prev_r = 1; m_prev_c = 1;
        end else begin
            se = bus.btnStart  && !m_prev_s;
            pe = bus.btnPause  && !m_prev_p;
            re = bus.btnReset  && !m_prev_r;
            ce = bus.collision && !m_prev_c;
            st = int'(bus.stateGame);
            e_start = 0; e_pause = 0; e_reset = 0;
            if (re && st != 3 && st <= 4)           e_reset = 1;
            else if (pe && st == 1)                 e_pause = 1;
            else if (se && (st == 0 || st == 2))    e_start = 1;
            e_tick = 0;
            if (st == 1) begin
                m_cnt++;
                if (m_cnt == TICK_DIV) begin
                    m_cnt  = 0;
                    e_tick = 1;
                end
            end else if (st != 2) begin
                m_cnt = 0;
            end
            e_dead = 0;
            if (st == 3) begin
                m_lives = LIVES;
            end else if (ce && st == 1 && m_lives > 0) begin
                m_lives--;
                e_dead = (m_lives == 0);
            end
            m_prev_s = bus.btnStart; m_prev_p = bus.btnPause;
            m_prev_r = bus.btnReset; m_prev_c = bus.collision;
        end
    endtask

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_btns(input bit s, input bit p, input bit r, input bit c);
        bus.btnStart = s; bus.btnPause = p; bus.btnReset = r; bus.collision = c;
    endtask

    task automatic test_reset();
        resetFSM = 1'b1;
        set_btns(0, 0, 0, 0);
        bus.stateGame = 3'b001;
        tick(); tick();
        checks++;
        if ({bus.startGame, bus.pauseGame, bus.reset, bus.dead, bus.stepTick} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_pulses got %b want 00000",
                     {bus.startGame, bus.pauseGame, bus.reset, bus.dead, bus.stepTick});
        end
        checks++;
        if (bus.lives !== 2'd3) begin
            errors++;
            $display("FAIL reset_lives got %0d want 3", bus.lives);
        end
        resetFSM = 1'b0;
    endtask

    task automatic test_start_hold();
        bus.stateGame = 3'b000;
        set_btns(0, 0, 0, 0);
        tick();
        bus.btnStart = 1'b1;
        tick();
        checks++;
        if (bus.startGame !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse got %b want 1", bus.startGame);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.startGame !== 1'b0) begin
                errors++;
                $display("FAIL start_held cycle %0d got %b want 0", i, bus.startGame);
            end
        end
        bus.btnStart = 1'b0;
        tick();
    endtask

    task automatic test_step_tick();
        bus.stateGame = 3'b000;
        tick();
        bus.stateGame = 3'b001;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (bus.stepTick !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL step_tick cycle %0d got %b want %b", i, bus.stepTick, (i % 4) == 0);
            end
        end
        // Two steps in, pause three cycles, then only two more steps are owed.
        tick(); tick();
        bus.stateGame = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.stepTick !== 1'b0) begin
                errors++;
                $display("FAIL step_paused cycle %0d got %b want 0", i, bus.stepTick);
            end
        end
        bus.stateGame = 3'b001;
        tick();
        checks++;
        if (bus.stepTick !== 1'b0) begin
            errors++;
            $display("FAIL step_resume_early got %b want 0", bus.stepTick);
        end
        tick();
        checks++;
        if (bus.stepTick !== 1'b1) begin
            errors++;
            $display("FAIL step_resume_remaining got %b want 1", bus.stepTick);
        end
    endtask

    task automatic test_priority();
        set_btns(0, 0, 0, 0);
        bus.stateGame = 3'b001;
        tick();
        set_btns(0, 1, 1, 0);
        tick();
        checks++;
        if ({bus.startGame, bus.pauseGame, bus.reset} !== 3'b001) begin
            errors++;
            $display("FAIL prio_reset_over_pause got %b want 001", {bus.startGame, bus.pauseGame, bus.reset});
        end
        set_btns(0, 0, 0, 0);
        bus.stateGame = 3'b011;
        tick();
        set_btns(1, 0, 1, 0);
        tick();
        checks++;
        if ({bus.startGame, bus.pauseGame, bus.reset} !== 3'b000) begin
            errors++;
            $display("FAIL prio_in_reset_state got %b want 000", {bus.startGame, bus.pauseGame, bus.reset});
        end
        set_btns(0, 0, 0, 0);
        bus.stateGame = 3'b010;
        tick();
        set_btns(1, 1, 0, 0);
        tick();
        checks++;
        if ({bus.startGame, bus.pauseGame, bus.reset} !== 3'b100) begin
            errors++;
            $display("FAIL prio_rejected_pause got %b want 100", {bus.startGame, bus.pauseGame, bus.reset});
        end
        set_btns(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_lives();
        int  want_lives [4] = '{2, 1, 0, 0};
        bit  want_dead  [4] = '{0, 0, 1, 0};
        set_btns(0, 0, 0, 0);
        bus.stateGame = 3'b011;
        tick();
        bus.stateGame = 3'b001;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.collision = 1'b1;
            tick();
            checks++;
            if (bus.lives !== 2'(want_lives[i]) || bus.dead !== want_dead[i]) begin
                errors++;
                $display("FAIL lives_hit %0d got lives=%0d dead=%b want lives=%0d dead=%b",
                         i, bus.lives, bus.dead, want_lives[i], want_dead[i]);
            end
            bus.collision = 1'b0;
            tick();
            checks++;
            if (bus.dead !== 1'b0) begin
                errors++;
                $display("FAIL dead_once %0d got %b want 0", i, bus.dead);
            end
        end
    endtask

    task automatic test_reset_hold();
        bus.stateGame = 3'b000;
        set_btns(1, 0, 0, 0);
        resetFSM = 1'b1;
        tick(); tick();
        resetFSM = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.startGame !== 1'b0) begin
                errors++;
                $display("FAIL held_through_reset cycle %0d got %b want 0", i, bus.startGame);
            end
        end
        bus.btnStart = 1'b0;
        tick();
        bus.btnStart = 1'b1;
        tick();
        checks++;
        if (bus.startGame !== 1'b1) begin
            errors++;
            $display("FAIL repress_after_reset got %b want 1", bus.startGame);
        end
        bus.btnStart = 1'b0;
        tick();
    endtask

    task automatic test_reset_cancel();
        set_btns(0, 0, 0, 0);
        bus.stateGame = 3'b011;
        tick();
        bus.stateGame = 3'b001;
        for (int i = 0; i < 2; i++) begin
            bus.collision = 1'b1; tick();
            bus.collision = 1'b0; tick();
        end
        checks++;
        if (bus.lives !== 2'd1) begin
            errors++;
            $display("FAIL cancel_setup_lives got %0d want 1", bus.lives);
        end
        // Last-life collision edge coincides with reset: reset wins.
        bus.collision = 1'b1;
        resetFSM = 1'b1;
        tick();
        resetFSM = 1'b0;
        bus.collision = 1'b0;
        tick();
        checks++;
        if (bus.dead !== 1'b0 || bus.lives !== 2'd3) begin
            errors++;
            $display("FAIL reset_cancels_dead got dead=%b lives=%0d want dead=0 lives=3", bus.dead, bus.lives);
        end
    endtask

    task automatic test_random();
        resetFSM = 1'b1;
        set_btns(0, 0, 0, 0);
        tick();
        resetFSM = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) < 8) bus.stateGame = 3'($urandom_range(0, 4));
                else                          bus.stateGame = 3'($urandom_range(5, 7));
            end
            if ($urandom_range(0, 3) == 0) bus.btnStart  = ~bus.btnStart;
            if ($urandom_range(0, 3) == 0) bus.btnPause  = ~bus.btnPause;
            if ($urandom_range(0, 3) == 0) bus.btnReset  = ~bus.btnReset;
            if ($urandom_range(0, 2) == 0) bus.collision = ~bus.collision;
            resetFSM = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if ({bus.startGame, bus.pauseGame, bus.reset, bus.dead, bus.stepTick} !==
                {e_start, e_pause, e_reset, e_dead, e_tick} || bus.lives !== 2'(m_lives)) begin
                errors++;
                $display("FAIL random cycle %0d got spr_d_t=%b lives=%0d want spr_d_t=%b lives=%0d",
                         n, {bus.startGame, bus.pauseGame, bus.reset, bus.dead, bus.stepTick}, bus.lives,
                         {e_start, e_pause, e_reset, e_dead, e_tick}, m_lives);
            end
        end
        resetFSM = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetFSM = 1'b1;
        set_btns(0, 0, 0, 0);
        bus.stateGame = 3'b000;
        test_reset();
        test_start_hold();
        test_step_tick();
        test_priority();
        test_lives();
        test_reset_hold();
        test_reset_cancel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
